// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with one write port, two
// combinational read ports, hardwired-zero register 0, a flattened debug view
// and a sequenced clear engine that zeroes registers 1..DEPTH-1, one per cycle.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding to rd1/rd2).
module regfile_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we3,
    input  logic [AW-1:0]          wa3,
    input  logic [WIDTH-1:0]       wd3,
    input  logic [AW-1:0]          ra1,
    input  logic [AW-1:0]          ra2,
    output logic [WIDTH-1:0]       rd1,
    output logic [WIDTH-1:0]       rd2,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   wr_drop,
    output logic [DEPTH*WIDTH-1:0] dbg_regs
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] ADDR_ZERO = '0;
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             wr_drop_q, wr_drop_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_valid_s;

    // A write request that names a real (non-zero) register
    assign wr_valid_s = we3 && (wa3 != ADDR_ZERO);

    // State, pointer, drop flag and storage flops; reset aborts any clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Clear sequencer next state: start on clr_req, walk ptr up to DEPTH-1
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = ADDR_ONE;
                end else begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_q;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == ADDR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = ADDR_ZERO;
                end else begin
                    state_d = ST_CLEAR;
                    ptr_d   = ptr_q + ADDR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = ADDR_ZERO;
            end
        endcase
    end

    // Storage update: normal writes in IDLE, one register zeroed per CLEAR edge
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        wr_drop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_valid_s) begin
                    regs_d[wa3] = wd3;
                end else begin
                    wr_drop_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                regs_d[ptr_q] = '0;
                wr_drop_d     = wr_valid_s;
            end
            default: begin
                wr_drop_d = 1'b0;
            end
        endcase
        // Register 0 is hardwired to zero regardless of any path above
        regs_d[0] = '0;
    end

    // Outputs: busy decoded from state, read ports from storage (optionally forwarded)
    always_comb begin
        busy    = (state_q == ST_CLEAR);
        wr_drop = wr_drop_q;
        rd1     = regs_q[ra1];
        rd2     = regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
        if ((state_q == ST_IDLE) && wr_valid_s && (wa3 == ra1)) begin
            rd1 = wd3;
        end else begin
            rd1 = regs_q[ra1];
        end
        if ((state_q == ST_IDLE) && wr_valid_s && (wa3 == ra2)) begin
            rd2 = wd3;
        end else begin
            rd2 = regs_q[ra2];
        end
`else
        if (ra1 == ADDR_ZERO) begin
            rd1 = '0;
        end else begin
            rd1 = regs_q[ra1];
        end
        if (ra2 == ADDR_ZERO) begin
            rd2 = '0;
        end else begin
            rd2 = regs_q[ra2];
        end
`endif
    end

    // Debug view always shows stored contents, never forwarded data
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dbg
        assign dbg_regs[gi*WIDTH +: WIDTH] = regs_q[gi];
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (WIDTH=8, DEPTH=8): directed vector
// table, hand-written clear / reset sequences, and randomized traffic checked
// against a behavioural model of the register bank.
module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [2:0]  wa3;
    logic [7:0]  wd3;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic        clr_req;
    logic        busy;
    logic        wr_drop;
    logic [63:0] dbg_regs;

    int n_chk;
    int n_err;

    // Behavioural model: register contents plus how many registers remain to clear
    int mem [8];
    int clr_left;
    bit m_drop;

    regfile_param #(.WIDTH(8), .DEPTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_drop (wr_drop),
        .dbg_regs(dbg_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 8; r++) mem[r] = 0;
        clr_left = 0;
        m_drop   = 1'b0;
    endfunction

    function automatic int model_rd(input int a, input bit we, input int wa, input int wd);
        int v;
        v = mem[a];
`ifdef REGFILE_BYPASS_EN
        if (clr_left == 0 && we && wa != 0 && wa == a) v = wd;
`endif
        return v;
    endfunction

    function automatic void model_edge(input bit we, input int wa, input int wd, input bit clr);
        m_drop = 1'b0;
        if (clr_left == 0) begin
            if (we && wa != 0) mem[wa] = wd;
            if (clr) clr_left = 7;
        end else begin
            m_drop = we && (wa != 0);
            mem[8 - clr_left] = 0;
            clr_left--;
        end
    endfunction

    // One clock cycle: called just after a rising edge; checks reads before the
    // next edge and state/debug outputs just after it.
    task automatic cycle(input bit we, input int wa, input int wd,
                         input int a1, input int a2, input bit clr);
        we3 = we; wa3 = 3'(wa); wd3 = 8'(wd);
        ra1 = 3'(a1); ra2 = 3'(a2); clr_req = clr;
        @(negedge clk);
        chk("rd1", rd1, 64'(model_rd(a1, we, wa, wd)));
        chk("rd2", rd2, 64'(model_rd(a2, we, wa, wd)));
        model_edge(we, wa, wd, clr);
        @(posedge clk);
        #1;
        chk("busy", busy, 64'(clr_left != 0));
        chk("wr_drop", wr_drop, 64'(m_drop));
        for (int r = 0; r < 8; r++) chk("dbg", dbg_regs[r*8 +: 8], 64'(mem[r]));
    endtask

    typedef struct {
        bit we; int wa; int wd; int a1; int a2; int e1; int e2;
    } vec_t;

    vec_t tbl [7];
    int   busy_cnt;
    int   exp_byp;

    initial begin
        n_chk = 0; n_err = 0;
        tbl[0] = '{1'b1, 3, 'hA5, 3, 0, 'hA5, 'h00};
        tbl[1] = '{1'b1, 0, 'hFF, 0, 3, 'h00, 'hA5};
        tbl[2] = '{1'b1, 5, 'h3C, 5, 3, 'h3C, 'hA5};
        tbl[3] = '{1'b1, 7, 'h77, 7, 5, 'h77, 'h3C};
        tbl[4] = '{1'b0, 7, 'hEE, 7, 1, 'h77, 'h00};
        tbl[5] = '{1'b1, 1, 'h01, 1, 2, 'h01, 'h00};
        tbl[6] = '{1'b1, 3, 'h5A, 3, 7, 'h5A, 'h77};

        rst_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0;
        ra1 = 3'd3; ra2 = 3'd5; clr_req = 1'b0;
        model_reset();
        #12;
        chk("rst_rd1", rd1, 64'h0);
        chk("rst_rd2", rd2, 64'h0);
        chk("rst_dbg", dbg_regs, 64'h0);
        chk("rst_busy", busy, 64'h0);
        chk("rst_drop", wr_drop, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed write/read table
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2, 1'b0);
            we3 = 1'b0;
            #1;
            chk("tbl_rd1", rd1, 64'(tbl[i].e1));
            chk("tbl_rd2", rd2, 64'(tbl[i].e2));
        end

        // Same-cycle visibility of a write (forwarded only with the bypass build)
        cycle(1'b1, 5, 'h10, 0, 0, 1'b0);
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h3C; ra2 = 3'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 'h3C;
`else
        exp_byp = 'h10;
`endif
        chk("bypass_rd2", rd2, 64'(exp_byp));
        cycle(1'b1, 5, 'h3C, 5, 5, 1'b0);
        we3 = 1'b0;
        #1;
        chk("after_wr_rd2", rd2, 64'h3C);

        // Asynchronous reset asserted mid-cycle with live contents
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rd1", rd1, 64'h0);
        chk("async_rd2", rd2, 64'h0);
        chk("async_dbg", dbg_regs, 64'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full clear with a dropped write in the third busy cycle
        for (int k = 1; k < 8; k++) cycle(1'b1, k, k * 'h11, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 7, 1, 1'b1);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int j = 1; j < 8; j++) begin
            if (j == 3) cycle(1'b1, 2, 'h99, j, 7, 1'b0);
            else        cycle(1'b0, 0, 0, j, 7, 1'b0);
            if (busy === 1'b1) busy_cnt++;
            if (j == 3) chk("drop_pulse", wr_drop, 64'h1);
            if (j == 4) chk("drop_end", wr_drop, 64'h0);
            we3 = 1'b0;
            #1;
            chk("clr_regk", rd1, 64'h0);
            if (j < 7) chk("clr_reg7_old", rd2, 64'h77);
        end
        chk("busy_len", 64'(busy_cnt), 64'd7);
        chk("clr_busy_done", busy, 64'h0);
        chk("clr_dbg_zero", dbg_regs, 64'h0);

        // Reset during the fourth busy cycle aborts the clear
        for (int k = 1; k < 8; k++) cycle(1'b1, k, k * 'h10 + k, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 0, 0, 1'b1);
        for (int j = 1; j < 4; j++) cycle(1'b0, 0, 0, 5, 6, 1'b0);
        chk("pre_abort_busy", busy, 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort_busy", busy, 64'h0);
        chk("abort_dbg", dbg_regs, 64'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 6, 'h42, 6, 0, 1'b0);
        cycle(1'b0, 0, 0, 6, 6, 1'b0);
        chk("post_abort_rd1", rd1, 64'h42);
        chk("post_abort_busy", busy, 64'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
